// File: rtl/dynamic_buffer_insert_arbiter.sv
// ============================================================================
// Module   : dynamic_buffer_insert_arbiter
// Purpose  : Round-robin sharing of the packet-buffer insert port among
//            CHNL_NUM channels; grant held from first beat to response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dynamic_buffer_insert_arbiter #(
  parameter int CHNL_NUM   = 3,
  parameter int DATA_WIDTH = 512,
  parameter int HEAD_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHNL_NUM-1:0]            chnl_req_valid,
  input  logic [CHNL_NUM-1:0]            chnl_req_start,
  input  logic [CHNL_NUM-1:0]            chnl_req_last,
  input  logic [CHNL_NUM*DATA_WIDTH-1:0] chnl_req_data,
  output logic [CHNL_NUM-1:0]            chnl_req_ready,
  output logic [CHNL_NUM-1:0]            chnl_resp_valid,
  output logic [CHNL_NUM*HEAD_WIDTH-1:0] chnl_resp_head,
  input  logic [CHNL_NUM-1:0]            chnl_resp_ready,
  output logic                           insert_req_valid,
  output logic                           insert_req_start,
  output logic                           insert_req_last,
  output logic [DATA_WIDTH-1:0]          insert_req_data,
  input  logic                           insert_req_ready,
  input  logic                           insert_resp_valid,
  input  logic [HEAD_WIDTH-1:0]          insert_resp_head,
  output logic                           insert_resp_ready,
  output logic                           arb_busy
);

  localparam int IDX_W = (CHNL_NUM > 1) ? $clog2(CHNL_NUM) : 1;
  localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(CHNL_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_last_idx;

  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_beat_done;
  logic             w_resp_done;

  // Scan from farthest to nearest so the nearest valid channel after r_last_idx wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int k = CHNL_NUM; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_last_idx) + k) % CHNL_NUM);
      if (chnl_req_valid[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  always_comb begin
    chnl_req_ready    = '0;
    chnl_resp_valid   = '0;
    chnl_resp_head    = '0;
    insert_req_valid  = 1'b0;
    insert_req_start  = 1'b0;
    insert_req_last   = 1'b0;
    insert_req_data   = '0;
    insert_resp_ready = 1'b0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      if (IDX_W'(i) == r_grant_idx) begin
        if (r_state == S_DATA) begin
          insert_req_valid  = chnl_req_valid[i];
          insert_req_start  = chnl_req_start[i];
          insert_req_last   = chnl_req_last[i];
          insert_req_data   = chnl_req_data[i*DATA_WIDTH +: DATA_WIDTH];
          chnl_req_ready[i] = insert_req_ready;
        end
        if (r_state == S_RESP) begin
          chnl_resp_valid[i]                          = insert_resp_valid;
          chnl_resp_head[i*HEAD_WIDTH +: HEAD_WIDTH]  = insert_resp_head;
          insert_resp_ready                           = chnl_resp_ready[i];
        end
      end
    end
  end

  // Outputs above are already gated by state, so these are true handshakes.
  assign w_beat_done = insert_req_valid & insert_req_ready & insert_req_last;
  assign w_resp_done = insert_resp_valid & insert_resp_ready;
  assign arb_busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= C_LAST_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_grant_idx <= w_sel_idx;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat_done) r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_done) begin
            r_last_idx <= r_grant_idx;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dynamic_buffer_insert_arbiter.sv
// ============================================================================
// Module   : tb_dynamic_buffer_insert_arbiter
// Purpose  : Directed bench with a transaction-level arbiter model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dynamic_buffer_insert_arbiter;

  localparam int CH = 3;
  localparam int DW = 512;
  localparam int HW = 24;

  logic clk, rst;
  logic [CH-1:0]    req_valid, req_start, req_last, req_ready, resp_valid, resp_ready;
  logic [CH*DW-1:0] req_data;
  logic [CH*HW-1:0] resp_head;
  logic             ins_valid, ins_start, ins_last, ins_ready;
  logic             ins_resp_valid, ins_resp_ready, busy;
  logic [DW-1:0]    ins_data;
  logic [HW-1:0]    ins_resp_head;

  dynamic_buffer_insert_arbiter #(.CHNL_NUM(CH), .DATA_WIDTH(DW), .HEAD_WIDTH(HW)) dut (
    .clk(clk), .rst(rst),
    .chnl_req_valid(req_valid), .chnl_req_start(req_start), .chnl_req_last(req_last),
    .chnl_req_data(req_data), .chnl_req_ready(req_ready),
    .chnl_resp_valid(resp_valid), .chnl_resp_head(resp_head), .chnl_resp_ready(resp_ready),
    .insert_req_valid(ins_valid), .insert_req_start(ins_start), .insert_req_last(ins_last),
    .insert_req_data(ins_data), .insert_req_ready(ins_ready),
    .insert_resp_valid(ins_resp_valid), .insert_resp_head(ins_resp_head),
    .insert_resp_ready(ins_resp_ready), .arb_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel sources: each sends pk_left packets of nbeats beats, payload = base+beat.
  int          pk_left[CH], nbeats[CH], beat_no[CH];
  logic [31:0] base[CH];
  // Buffer-side sink: response pending after a last beat, or forced early.
  bit          pending, early, rand_mode;
  logic [HW-1:0] next_head;
  int          n_beats_hs;
  int          grant_log[$];
  logic [HW-1:0] last_head[CH];

  task automatic drive_src();
    for (int i = 0; i < CH; i++) begin
      req_valid[i] = (pk_left[i] > 0);
      req_start[i] = (beat_no[i] == 0);
      req_last[i]  = (beat_no[i] == nbeats[i] - 1);
      req_data[i*DW +: DW] = {16{base[i] + 32'(beat_no[i])}};
    end
    ins_resp_valid = pending | early;
    ins_resp_head  = next_head;
  endtask

  task automatic cyc();
    bit hs[CH];
    bit last_hs, resp_hs;
    @(negedge clk);
    for (int i = 0; i < CH; i++) hs[i] = req_valid[i] && req_ready[i];
    if (ins_valid && ins_ready) n_beats_hs++;
    last_hs = ins_valid && ins_ready && ins_last;
    resp_hs = ins_resp_valid && ins_resp_ready;
    for (int i = 0; i < CH; i++)
      if (resp_valid[i] && resp_ready[i]) begin
        grant_log.push_back(i);
        last_head[i] = resp_head[i*HW +: HW];
      end
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++)
      if (hs[i]) begin
        if (beat_no[i] == nbeats[i] - 1) begin
          beat_no[i] = 0;
          pk_left[i]--;
          base[i] = base[i] + 32'h10;
        end else beat_no[i]++;
      end
    if (resp_hs) begin
      pending = 1'b0;
      early = 1'b0;
      next_head = next_head + 1'b1;
    end
    if (last_hs) pending = 1'b1;
    if (rand_mode) begin
      ins_ready  = 1'($urandom_range(0, 1));
      resp_ready = CH'($urandom_range(0, 7));
    end
    drive_src();
    #1;
  endtask

  task automatic run_until(input int target, input int budget, input string nm, output int used);
    used = 0;
    while (grant_log.size() < target && used < budget) begin
      cyc();
      used++;
    end
    chk({nm, "_done"}, 512'(grant_log.size() >= target), 512'd1);
  endtask

  // Transaction model: owner of the port, whether its response is awaited, last served.
  int   m_owner = -1;
  bit   m_wait = 1'b0;
  int   m_recent = CH - 1;
  bit   m_pick;
  logic [CH-1:0]    e_req_ready, e_resp_valid;
  logic [CH*HW-1:0] e_resp_head;
  logic             e_valid, e_start, e_last, e_resp_ready, e_busy;
  logic [DW-1:0]    e_data;

  always @(negedge clk) begin
    e_req_ready = '0; e_resp_valid = '0; e_resp_head = '0;
    e_valid = 0; e_start = 0; e_last = 0; e_data = '0; e_resp_ready = 0; e_busy = 0;
    if (rst) begin
      m_owner = -1; m_wait = 0; m_recent = CH - 1;
    end else if (m_owner >= 0) begin
      e_busy = 1;
      if (!m_wait) begin
        e_valid = req_valid[m_owner];
        e_start = req_start[m_owner];
        e_last  = req_last[m_owner];
        e_data  = req_data[m_owner*DW +: DW];
        e_req_ready[m_owner] = ins_ready;
      end else begin
        e_resp_valid[m_owner] = ins_resp_valid;
        e_resp_head[m_owner*HW +: HW] = ins_resp_head;
        e_resp_ready = resp_ready[m_owner];
      end
    end
    chk("busy", 512'(busy), 512'(e_busy));
    chk("ins_valid", 512'(ins_valid), 512'(e_valid));
    chk("ins_start", 512'(ins_start), 512'(e_start));
    chk("ins_last", 512'(ins_last), 512'(e_last));
    chk("ins_data", ins_data, e_data);
    chk("req_ready", 512'(req_ready), 512'(e_req_ready));
    chk("resp_valid", 512'(resp_valid), 512'(e_resp_valid));
    chk("resp_head", 512'(resp_head), 512'(e_resp_head));
    chk("ins_resp_ready", 512'(ins_resp_ready), 512'(e_resp_ready));
    if (!rst) begin
      if (m_owner < 0) begin
        m_pick = 0;
        for (int k = 1; k <= CH; k++)
          if (!m_pick && req_valid[(m_recent + k) % CH]) begin
            m_pick = 1;
            m_owner = (m_recent + k) % CH;
          end
      end else if (!m_wait) begin
        if (req_valid[m_owner] && ins_ready && req_last[m_owner]) m_wait = 1;
      end else if (ins_resp_valid && resp_ready[m_owner]) begin
        m_recent = m_owner; m_owner = -1; m_wait = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int used, b0, saw;
  int exp2[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1; ins_ready = 1; resp_ready = '1;
    pending = 0; early = 0; rand_mode = 0; next_head = 24'h00ABCD; n_beats_hs = 0;
    for (int i = 0; i < CH; i++) begin
      pk_left[i] = 0; nbeats[i] = 1; beat_no[i] = 0; base[i] = 32'(i) << 8;
    end
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_ins_valid", 512'(ins_valid), 512'd0);
    rst = 0;
    #1;

    // Channel 1, 3-beat packet, head 0x00ABCD
    nbeats[1] = 3; pk_left[1] = 1; base[1] = 32'h100; drive_src(); #1;
    chk("t1_idle_ready", 512'(req_ready), 512'd0);
    cyc();
    chk("t1_ready_c1", 512'(req_ready), 512'b010);
    chk("t1_beat0", ins_data, {16{32'h100}});
    chk("t1_start0", 512'(ins_start), 512'd1);
    cyc();
    chk("t1_beat1", ins_data, {16{32'h101}});
    run_until(1, 20, "t1", used);
    chk("t1_head", 512'(last_head[1]), 512'h00ABCD);
    chk("t1_grant", 512'(grant_log[0]), 512'd1);

    // last_idx=1: ch0+ch2 -> 2 then 0; then ch1+ch2 -> 1 then 2
    nbeats[0] = 1; pk_left[0] = 1; nbeats[2] = 1; pk_left[2] = 1; drive_src(); #1;
    run_until(3, 30, "t1b", used);
    chk("t1b_g0", 512'(grant_log[1]), 512'd2);
    chk("t1b_g1", 512'(grant_log[2]), 512'd0);
    nbeats[1] = 1; pk_left[1] = 1; pk_left[2] = 1; drive_src(); #1;
    run_until(5, 30, "t1c", used);
    chk("t1c_g0", 512'(grant_log[3]), 512'd1);
    chk("t1c_g1", 512'(grant_log[4]), 512'd2);

    // All channels continuously valid, single-beat packets
    b0 = grant_log.size();
    for (int i = 0; i < CH; i++) begin nbeats[i] = 1; pk_left[i] = 2; end
    drive_src(); #1;
    run_until(b0 + 6, 40, "t2", used);
    chk("t2_cycles", 512'(used), 512'd18);
    for (int k = 0; k < 6; k++) chk("t2_order", 512'(grant_log[b0 + k]), 512'(exp2[k]));

    // Channel 0 mid-packet; channel 2 must wait
    b0 = grant_log.size();
    nbeats[0] = 4; pk_left[0] = 1; drive_src(); #1;
    cyc(); cyc();
    nbeats[2] = 1; pk_left[2] = 1; drive_src(); #1;
    saw = 0;
    for (int k = 0; k < 20 && grant_log.size() < b0 + 1; k++) begin
      if (req_ready[2]) saw = 1;
      cyc();
    end
    chk("t3_ch2_blocked", 512'(saw), 512'd0);
    run_until(b0 + 2, 20, "t3", used);
    chk("t3_g0", 512'(grant_log[b0]), 512'd0);
    chk("t3_g1", 512'(grant_log[b0 + 1]), 512'd2);

    // Early response during DATA
    b0 = grant_log.size();
    nbeats[1] = 4; pk_left[1] = 1; early = 1; next_head = 24'h000777; drive_src(); #1;
    cyc(); cyc();
    chk("t4_ins_resp_ready", 512'(ins_resp_ready), 512'd0);
    chk("t4_resp_valid", 512'(resp_valid), 512'd0);
    run_until(b0 + 1, 20, "t4", used);
    chk("t4_head", 512'(last_head[1]), 512'h000777);

    // Random backpressure, 4-beat packets on all channels
    b0 = grant_log.size();
    saw = n_beats_hs;
    rand_mode = 1;
    for (int i = 0; i < CH; i++) begin nbeats[i] = 4; pk_left[i] = 1; end
    drive_src(); #1;
    run_until(b0 + 3, 300, "t5", used);
    rand_mode = 0; ins_ready = 1; resp_ready = '1; drive_src(); #1;
    chk("t5_beats", 512'(n_beats_hs - saw), 512'd12);
    chk("t5_left", 512'(pk_left[0] + pk_left[1] + pk_left[2]), 512'd0);

    // Serve ch0 so ch1 would normally win next; reset mid-packet restores ch0 priority
    b0 = grant_log.size();
    nbeats[0] = 1; pk_left[0] = 1; drive_src(); #1;
    run_until(b0 + 1, 20, "t6a", used);
    nbeats[1] = 4; pk_left[1] = 1; drive_src(); #1;
    for (int k = 0; k < 10 && !(req_ready[1] && beat_no[1] == 1); k++) cyc();
    chk("t6_at_beat2", 512'(req_ready[1] && beat_no[1] == 1), 512'd1);
    rst = 1;
    #1;
    chk("t6_busy", 512'(busy), 512'd0);
    chk("t6_ins_valid", 512'(ins_valid), 512'd0);
    chk("t6_req_ready", 512'(req_ready), 512'd0);
    chk("t6_ins_data", ins_data, '0);
    cyc(); cyc();
    rst = 0;
    pending = 0; early = 0;
    for (int i = 0; i < CH; i++) begin pk_left[i] = 0; beat_no[i] = 0; end
    b0 = grant_log.size();
    nbeats[0] = 1; pk_left[0] = 1; nbeats[1] = 1; pk_left[1] = 1; drive_src(); #1;
    run_until(b0 + 2, 20, "t6", used);
    chk("t6_g0", 512'(grant_log[b0]), 512'd0);
    chk("t6_g1", 512'(grant_log[b0 + 1]), 512'd1);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
